// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
//   reg_op_t       : bus-register control operation (read = latch, write = drive)
//   memalu_op_t    : memory-address ALU operation codes used by the datapath
//   memctl_state_t : controller state encoding
//   MEMCTL_TIMEOUT : default ACCESS wait budget in cycles
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2
    } reg_op_t;

    typedef enum logic [1:0] {
        MEMALU_PASS = 2'd0,
        MEMALU_INC  = 2'd1,
        MEMALU_DEC  = 2'd2,
        MEMALU_ADD  = 2'd3
    } memalu_op_t;

    typedef enum logic [1:0] {
        MEMCTL_IDLE   = 2'd0,
        MEMCTL_SETUP  = 2'd1,
        MEMCTL_ACCESS = 2'd2,
        MEMCTL_DONE   = 2'd3
    } memctl_state_t;

    localparam int MEMCTL_TIMEOUT = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// ACCESS-phase wait counter.
//   clk, rst : system clock, synchronous active-high reset
//   clear    : zero the count (asserted the cycle before ACCESS is entered)
//   enable   : count one waiting cycle
//   expired  : high in the waiting cycle whose increment reaches TIMEOUT
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is flagged combinationally so the controller leaves ACCESS on the
    // same edge the count reaches TIMEOUT, giving exactly TIMEOUT wait cycles.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-access memory controller between a register bus and a memory port.
//   clk, rst             : system clock, synchronous active-high reset
//   addr_in, addr_ctl    : address bus; REG_OP_READ latches it while idle
//   data_in, data_ctl    : write data; REG_OP_WRITE drives read data on data_out
//   start, we            : launch an access (we=1 write, 0 read)
//   data_out             : captured read data or high-impedance
//   busy, done, err      : status
//   mem_*                : memory-side address, write data, strobes, read data, ready
//
// state  | meaning
// IDLE   | waiting for start; address may be latched
// SETUP  | one cycle of address/data setup, strobes low
// ACCESS | strobe asserted, waiting for mem_ready or timeout
// DONE   | one-cycle completion pulse
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int HALF_WIDTH = 8,
    parameter int TIMEOUT    = MEMCTL_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*HALF_WIDTH-1:0] addr_in,
    input  reg_op_t                 addr_ctl,
    input  logic [HALF_WIDTH-1:0]   data_in,
    input  reg_op_t                 data_ctl,
    input  logic                    start,
    input  logic                    we,
    output logic [HALF_WIDTH-1:0]   data_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2*HALF_WIDTH-1:0] mem_addr,
    output logic [HALF_WIDTH-1:0]   mem_wdata,
    output logic                    mem_re,
    output logic                    mem_we,
    input  logic [HALF_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    memctl_state_t state_q, state_d;

    logic [2*HALF_WIDTH-1:0] addr_q;
    logic [HALF_WIDTH-1:0]   wdata_q;
    logic [HALF_WIDTH-1:0]   rdata_q;
    logic                    we_q;
    logic                    err_q;

    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            MEMCTL_IDLE: begin
                if (start) begin
                    state_d = MEMCTL_SETUP;
                end
            end
            MEMCTL_SETUP: begin
                timer_clr = 1'b1;
                state_d   = MEMCTL_ACCESS;
            end
            MEMCTL_ACCESS: begin
                if (mem_ready) begin
                    state_d = MEMCTL_DONE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) begin
                        state_d = MEMCTL_DONE;
                    end
                end
            end
            MEMCTL_DONE: begin
                state_d = MEMCTL_IDLE;
            end
            default: begin
                state_d = MEMCTL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEMCTL_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == MEMCTL_IDLE) begin
                // Same-cycle latch and start: the access sees the new address
                // because mem_addr is only used from SETUP onward.
                if (addr_ctl == REG_OP_READ) begin
                    addr_q <= addr_in;
                end
                if (start) begin
                    we_q <= we;
                    if (we) begin
                        wdata_q <= data_in;
                    end
                end
            end
            if (state_q == MEMCTL_ACCESS) begin
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_q <= mem_rdata;
                    end
                    err_q <= 1'b0;
                end else if (timer_expired) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state_q != MEMCTL_IDLE);
    assign done      = (state_q == MEMCTL_DONE);
    assign err       = err_q;
    assign mem_re    = (state_q == MEMCTL_ACCESS) && !we_q;
    assign mem_we    = (state_q == MEMCTL_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign data_out  = (data_ctl == REG_OP_WRITE) ? rdata_q : {HALF_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int HW = 8;
    localparam int AW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_in;
    reg_op_t       addr_ctl;
    logic [HW-1:0] data_in;
    reg_op_t       data_ctl;
    logic          start;
    logic          we;
    wire  [HW-1:0] data_out;
    logic          busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [HW-1:0] mem_wdata;
    logic          mem_re, mem_we;
    logic [HW-1:0] mem_rdata;
    logic          mem_ready;

    mem_ctrl #(.HALF_WIDTH(HW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_in   (addr_in),
        .addr_ctl  (addr_ctl),
        .data_in   (data_in),
        .data_ctl  (data_ctl),
        .start     (start),
        .we        (we),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: architectural state after each completed access
    logic [AW-1:0] m_addr;
    logic [HW-1:0] m_wdata;
    logic [HW-1:0] m_rdata;
    logic          m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_err   = 1'b0;
    endtask

    // Simulators without 4-state nets may show an undriven bus as zero.
    task automatic check_data_out();
        logic hiz;
        data_ctl = REG_OP_WRITE;
        #1;
        check_eq("data_out_drive", data_out, m_rdata);
        data_ctl = REG_OP_NONE;
        #1;
        hiz = (data_out === {HW{1'bz}}) || (data_out === {HW{1'b0}});
        check_eq("data_out_hiz", hiz, 1'b1);
    endtask

    // One full access. delay = ACCESS cycles with mem_ready low before it rises.
    task automatic run_access(input bit w, input bit load, input logic [AW-1:0] a,
                              input logic [HW-1:0] d, input int delay,
                              input logic [HW-1:0] rd, input bit noise);
        bit ok;
        int exp_strobe;
        int busy_n, re_n, we_n, done_n, done_idx, acc;
        ok         = (delay < TO);
        exp_strobe = ok ? delay + 1 : TO;
        if (load) m_addr = a;
        if (w) m_wdata = d;
        if (ok && !w) m_rdata = rd;
        m_err = !ok;

        @(negedge clk);
        addr_in   = a;
        addr_ctl  = load ? REG_OP_READ : REG_OP_NONE;
        start     = 1'b1;
        we        = w;
        data_in   = d;
        mem_rdata = rd;
        mem_ready = 1'($urandom_range(0, 1));

        busy_n = 0; re_n = 0; we_n = 0; done_n = 0; done_idx = -1; acc = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start    = 1'b0;
            addr_ctl = REG_OP_NONE;
            we       = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            if (!busy) break;
            busy_n++;
            if (mem_re) re_n++;
            if (mem_we) we_n++;
            check_eq("strobe_excl", 32'(mem_re & mem_we), 0);
            check_eq("addr_stable", mem_addr, m_addr);
            if (done) begin
                done_n++;
                done_idx = c;
                check_eq("err_at_done", err, m_err);
            end
            if (mem_re || mem_we) begin
                mem_ready = (acc >= delay);
                acc++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (noise) begin
                start    = 1'b1;
                addr_ctl = REG_OP_READ;
                addr_in  = 16'($urandom);
            end
        end
        check_eq("terminated", busy, 0);
        check_eq("busy_cycles", busy_n, exp_strobe + 2);
        check_eq("re_cycles", re_n, w ? 0 : exp_strobe);
        check_eq("we_cycles", we_n, w ? exp_strobe : 0);
        check_eq("done_pulses", done_n, 1);
        check_eq("done_latency", done_idx, exp_strobe + 1);
        check_eq("err_sticky", err, m_err);
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("mem_addr", mem_addr, m_addr);
        check_data_out();
        @(negedge clk);
        check_eq("no_queue", busy, 0);
    endtask

    initial begin
        int done_seen;
        rst       = 1'b1;
        addr_in   = 16'hBEEF;
        addr_ctl  = REG_OP_READ;
        data_in   = 8'h11;
        data_ctl  = REG_OP_NONE;
        start     = 1'b1;
        we        = 1'b1;
        mem_rdata = 8'h00;
        mem_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_strobes", {mem_re, mem_we}, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        rst      = 1'b0;
        start    = 1'b0;
        addr_ctl = REG_OP_NONE;
        check_data_out();

        // read at 1234, immediate ready
        run_access(1'b0, 1'b1, 16'h1234, 8'h00, 0, 8'hA5, 1'b0);
        // write at 00FF, ready after 4 waiting cycles
        run_access(1'b1, 1'b1, 16'h00FF, 8'h3C, 4, 8'h5A, 1'b0);
        // read that times out, then a successful read clears err
        run_access(1'b0, 1'b0, 16'h0000, 8'h00, 1000, 8'h77, 1'b0);
        run_access(1'b0, 1'b0, 16'h0000, 8'h00, 2, 8'h96, 1'b0);
        // last-chance ready and first-timeout boundaries
        run_access(1'b0, 1'b1, 16'h4242, 8'h00, TO - 1, 8'hC3, 1'b0);
        run_access(1'b1, 1'b1, 16'h4343, 8'h81, TO, 8'h00, 1'b0);
        // start and address latch attempts while busy
        run_access(1'b0, 1'b1, 16'hABCD, 8'h00, 3, 8'h3E, 1'b1);

        for (int i = 0; i < 25; i++) begin
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                       8'($urandom), int'($urandom_range(0, TO + 3)), 8'($urandom),
                       1'($urandom_range(0, 1)));
        end

        // reset in the middle of ACCESS
        @(negedge clk);
        addr_in   = 16'h5555;
        addr_ctl  = REG_OP_READ;
        start     = 1'b1;
        we        = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        addr_ctl = REG_OP_NONE;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_re", mem_re, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_err", err, 0);
        check_eq("abort_strobes", {mem_re, mem_we}, 0);
        check_eq("abort_addr", mem_addr, 0);
        check_eq("abort_wdata", mem_wdata, 0);
        check_data_out();
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_eq("abort_no_done", done_seen, 0);

        // normal operation after abort
        run_access(1'b0, 1'b1, 16'h0F0F, 8'h00, 1, 8'h6D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
